// File: rtl/time_display_mux.sv
// rtl/time_display_mux.sv - four-digit multiplexed seven-segment driver for the remaining-time readout
module time_display_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 25
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [11:0] PresentTime,
  input  logic        Active,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic [3:0]  DigitSel
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic          r_run;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_index;
  logic [11:0]   r_snap;
  logic          r_active;
  logic          r_done;
  logic [FW-1:0] r_frame_cnt;
  logic          r_hidden;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_digit_sel;

  logic          w_load;
  logic [11:0]   w_snap;
  logic          w_dwell_wrap;
  logic          w_frame_end;
  logic          w_low_time;
  logic          w_fall;
  logic          w_rise;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;
  logic [3:0]    w_sel_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = SEG_E;
    endcase
  endfunction

  // Frame start takes PresentTime straight through so the whole frame decodes one consistent value.
  assign w_load       = (r_dwell == '0) && (r_index == 2'd0);
  assign w_snap       = w_load ? PresentTime : r_snap;
  assign w_dwell_wrap = (r_dwell == DWELL_LAST);
  assign w_frame_end  = r_run && w_dwell_wrap && (r_index == 2'd3);
  assign w_low_time   = Active && (w_snap[11:8] == 4'd0) && (w_snap[7:4] == 4'd0);
  assign w_fall       = r_active && !Active;
  assign w_rise       = !r_active && Active;

  // Decode the digit selected by the current scan position.
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_dp_nxt  = 1'b1;
    w_sel_nxt = ~(4'b0001 << r_index);
    case (r_index)
      2'd0: w_seg_nxt = (w_snap[3:0] > 4'd9) ? SEG_E : bcd_to_seg(w_snap[3:0]);
      2'd1: w_seg_nxt = (w_snap[7:4] > 4'd5) ? SEG_E : bcd_to_seg(w_snap[7:4]);
      2'd2: w_seg_nxt = (w_snap[11:8] > 4'd9) ? SEG_E : bcd_to_seg(w_snap[11:8]);
      default: w_seg_nxt = Active ? SEG_C : (r_done ? SEG_D : SEG_DASH);
    endcase
    if (r_hidden && (r_index != 2'd3)) begin
      w_seg_nxt = SEG_BLANK;
    end
    if ((r_index == 2'd2) && Active && !r_hidden) begin
      w_dp_nxt = 1'b0;
    end
  end

  // Scan timing: one idle cycle after reset, then dwell/index advance; snapshot at frame start.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_run   <= 1'b0;
      r_dwell <= '0;
      r_index <= 2'd0;
      r_snap  <= 12'h000;
    end else begin
      r_run <= 1'b1;
      if (w_load) begin
        r_snap <= PresentTime;
      end
      if (r_run) begin
        if (w_dwell_wrap) begin
          r_dwell <= '0;
          r_index <= r_index + 2'd1;
        end else begin
          r_dwell <= r_dwell + DW'(1);
        end
      end
    end
  end

  // Done latch: set when a session ends, cleared when a new one starts (rise wins).
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_active <= Active;
      if (w_rise) begin
        r_done <= 1'b0;
      end else if (w_fall) begin
        r_done <= 1'b1;
      end
    end
  end

  // Low-time blink: count completed frames and toggle the visible/hidden phase.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_frame_cnt <= '0;
      r_hidden    <= 1'b0;
    end else if (!w_low_time) begin
      r_frame_cnt <= '0;
      r_hidden    <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FRAME_LAST) begin
        r_frame_cnt <= '0;
        r_hidden    <= !r_hidden;
      end else begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  // Registered display outputs; all-off until the scan is running.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b1;
      r_digit_sel <= 4'b1111;
    end else if (!r_run) begin
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b1;
      r_digit_sel <= 4'b1111;
    end else begin
      r_seg       <= w_seg_nxt;
      r_dp        <= w_dp_nxt;
      r_digit_sel <= w_sel_nxt;
    end
  end

  assign Seg      = r_seg;
  assign Dp       = r_dp;
  assign DigitSel = r_digit_sel;

endmodule
